// File: rtl/user_seq_pkg.sv
// user_seq_pkg: shared constants, FSM state encoding and the one-hot helper
// used by the player-side sequence checker.
package user_seq_pkg;

  localparam int P_DATA_DEF = 4;
  localparam int P_KEY_DEF  = 4;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE     = 3'd0;
  localparam state_t ST_WAIT_KEY = 3'd1;
  localparam state_t ST_COMPARE  = 3'd2;
  localparam state_t ST_DONE_OK  = 3'd3;
  localparam state_t ST_DONE_ERR = 3'd4;

  // True when exactly one bit of v is set (v zero-extended by the caller).
  function automatic logic is_onehot(input logic [31:0] v);
    logic [31:0] m_s;
    m_s = v - 32'd1;
    return (v != 32'd0) && ((v & m_s) == 32'd0);
  endfunction

endpackage

// File: rtl/key_edge_detect.sv
// key_edge_detect: keeps one cycle of key history and reports per-key rising
// edges. 'single' means exactly one key rose and no other key is held, which
// is the only pattern the checker accepts as a valid press.
module key_edge_detect
  import user_seq_pkg::*;
#(
  parameter int P_KEY = P_KEY_DEF
) (
  input  logic             clk,
  input  logic             R,
  input  logic [P_KEY-1:0] key,
  output logic [P_KEY-1:0] rise,
  output logic             single
);

  logic [P_KEY-1:0] key_q_r;
  logic [31:0]      rise_ext_s;

  // Key history register: one-cycle delayed copy of the debounced keys.
  always_ff @(posedge clk or negedge R) begin
    if (!R) begin
      key_q_r <= '0;
    end else begin
      key_q_r <= key;
    end
  end

  assign rise       = key & ~key_q_r;
  assign rise_ext_s = 32'(rise);
  // A valid press: a lone rising key with nothing else held down.
  assign single     = is_onehot(rise_ext_s) && (key == rise);

endmodule

// File: rtl/user_seq_checker.sv
// user_seq_checker: walks the sequence ROM from address 0 to the round limit,
// one address per player key press, and reports round success (tc) or a wrong
// / multi-key press (err). Optional inactivity timeout is enabled by defining
// USER_TIMEOUT_EN; without it tmo stays 0 and no counter is built.
module user_seq_checker
  import user_seq_pkg::*;
#(
  parameter int P_DATA    = P_DATA_DEF,
  parameter int P_KEY     = P_KEY_DEF,
  parameter int P_TIMEOUT = 1000
) (
  input  logic              clk,
  input  logic              R,
  input  logic              E,
  input  logic [P_KEY-1:0]  KEY,
  input  logic [P_DATA-1:0] data,
  input  logic [P_KEY-1:0]  rom_q,
  output logic [P_DATA-1:0] SEQUSR,
  output logic              tc,
  output logic              err,
  output logic              tmo,
  output logic              busy
);

  if (P_TIMEOUT < 2) begin : g_bad_timeout
    $error("P_TIMEOUT must be at least 2");
  end

  state_t            state_r, state_nxt_s;
  logic [P_DATA-1:0] seq_r, seq_nxt_s;
  logic [P_KEY-1:0]  cap_r, cap_nxt_s;
  logic              tc_r, tc_nxt_s;
  logic              err_r, err_nxt_s;
  logic              tmo_r, tmo_nxt_s;
  logic              busy_r, busy_nxt_s;
  logic [P_KEY-1:0]  rise_s;
  logic              single_s;
  logic              key_event_s;
  logic              tmo_hit_s;

  key_edge_detect #(
    .P_KEY (P_KEY)
  ) u_edge (
    .clk    (clk),
    .R      (R),
    .key    (KEY),
    .rise   (rise_s),
    .single (single_s)
  );

  assign key_event_s = (rise_s != '0);

`ifdef USER_TIMEOUT_EN
  localparam int CNT_W = (P_TIMEOUT > 2) ? $clog2(P_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(P_TIMEOUT - 1);

  logic [CNT_W-1:0] cnt_r;

  // Inactivity counter: counts only while staying in WAIT_KEY, so it is zero
  // on every fresh entry to WAIT_KEY. It cannot pass CNT_LAST because
  // WAIT_KEY is always left on that cycle (key event or timeout).
  always_ff @(posedge clk or negedge R) begin
    if (!R) begin
      cnt_r <= '0;
    end else if ((state_r == ST_WAIT_KEY) && (state_nxt_s == ST_WAIT_KEY)) begin
      cnt_r <= cnt_r + CNT_W'(1);
    end else begin
      cnt_r <= '0;
    end
  end

  assign tmo_hit_s = (cnt_r == CNT_LAST);
`else
  assign tmo_hit_s = 1'b0;
`endif

  // Next-state and next-output logic for the turn FSM.
  always_comb begin
    state_nxt_s = state_r;
    seq_nxt_s   = seq_r;
    cap_nxt_s   = cap_r;
    tc_nxt_s    = tc_r;
    err_nxt_s   = err_r;
    tmo_nxt_s   = tmo_r;
    case (state_r)
      ST_IDLE: begin
        seq_nxt_s = '0;
        tc_nxt_s  = 1'b0;
        err_nxt_s = 1'b0;
        tmo_nxt_s = 1'b0;
        if (E) begin
          state_nxt_s = ST_WAIT_KEY;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_WAIT_KEY: begin
        if (!E) begin
          state_nxt_s = ST_IDLE;
          seq_nxt_s   = '0;
        end else if (single_s) begin
          cap_nxt_s   = rise_s;
          state_nxt_s = ST_COMPARE;
        end else if (key_event_s) begin
          state_nxt_s = ST_DONE_ERR;
          err_nxt_s   = 1'b1;
        end else if (tmo_hit_s) begin
          // Reached only without a key event, so a press on the expiry
          // cycle always takes precedence over the timeout.
          state_nxt_s = ST_DONE_ERR;
          err_nxt_s   = 1'b1;
          tmo_nxt_s   = 1'b1;
        end else begin
          state_nxt_s = ST_WAIT_KEY;
        end
      end
      ST_COMPARE: begin
        if (!E) begin
          state_nxt_s = ST_IDLE;
          seq_nxt_s   = '0;
        end else if (cap_r != rom_q) begin
          state_nxt_s = ST_DONE_ERR;
          err_nxt_s   = 1'b1;
        end else if (seq_r == data) begin
          state_nxt_s = ST_DONE_OK;
          tc_nxt_s    = 1'b1;
        end else if (seq_r < data) begin
          // seq_r < data guarantees the increment cannot wrap.
          seq_nxt_s   = seq_r + P_DATA'(1);
          state_nxt_s = ST_WAIT_KEY;
        end else begin
          // Limit was lowered below the current address mid-turn.
          state_nxt_s = ST_DONE_ERR;
          err_nxt_s   = 1'b1;
        end
      end
      ST_DONE_OK, ST_DONE_ERR: begin
        if (!E) begin
          state_nxt_s = ST_IDLE;
          seq_nxt_s   = '0;
          tc_nxt_s    = 1'b0;
          err_nxt_s   = 1'b0;
          tmo_nxt_s   = 1'b0;
        end else begin
          state_nxt_s = state_r;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
        seq_nxt_s   = '0;
        cap_nxt_s   = '0;
        tc_nxt_s    = 1'b0;
        err_nxt_s   = 1'b0;
        tmo_nxt_s   = 1'b0;
      end
    endcase
    busy_nxt_s = (state_nxt_s == ST_WAIT_KEY) || (state_nxt_s == ST_COMPARE);
  end

  // State and output registers; every output comes straight from a flop.
  always_ff @(posedge clk or negedge R) begin
    if (!R) begin
      state_r <= ST_IDLE;
      seq_r   <= '0;
      cap_r   <= '0;
      tc_r    <= 1'b0;
      err_r   <= 1'b0;
      tmo_r   <= 1'b0;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      seq_r   <= seq_nxt_s;
      cap_r   <= cap_nxt_s;
      tc_r    <= tc_nxt_s;
      err_r   <= err_nxt_s;
      tmo_r   <= tmo_nxt_s;
      busy_r  <= busy_nxt_s;
    end
  end

  assign SEQUSR = seq_r;
  assign tc     = tc_r;
  assign err    = err_r;
  assign tmo    = tmo_r;
  assign busy   = busy_r;

endmodule

// File: tb/tb_user_seq_checker.sv
// Testbench for user_seq_checker: a registered ROM model feeds rom_q, each
// scenario pushes the expected {SEQUSR, tc, err, tmo, busy} vector to a
// scoreboard queue as it drives stimulus and pops it when the result is due.
module tb_user_seq_checker;

  localparam int P_DATA    = 4;
  localparam int P_KEY     = 4;
  localparam int P_TIMEOUT = 8;

  logic              clk;
  logic              R;
  logic              E;
  logic [P_KEY-1:0]  KEY;
  logic [P_DATA-1:0] data;
  logic [P_KEY-1:0]  rom_q;
  logic [P_DATA-1:0] SEQUSR;
  logic              tc;
  logic              err;
  logic              tmo;
  logic              busy;

  logic [P_KEY-1:0]  rom [16];
  logic [7:0]        sb_q [$];
  logic [7:0]        exp_v;
  logic [7:0]        got_v;
  int                errors;
  int                checks;

  user_seq_checker #(
    .P_DATA    (P_DATA),
    .P_KEY     (P_KEY),
    .P_TIMEOUT (P_TIMEOUT)
  ) dut (
    .clk    (clk),
    .R      (R),
    .E      (E),
    .KEY    (KEY),
    .data   (data),
    .rom_q  (rom_q),
    .SEQUSR (SEQUSR),
    .tc     (tc),
    .err    (err),
    .tmo    (tmo),
    .busy   (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Registered ROM read port: data for SEQUSR appears one cycle later.
  always @(posedge clk) rom_q <= rom[SEQUSR];

  function automatic logic [7:0] pack(input logic [3:0] s, input logic t,
                                      input logic e, input logic m, input logic b);
    return {s, t, e, m, b};
  endfunction

  function automatic logic [7:0] observed();
    return {SEQUSR, tc, err, tmo, busy};
  endfunction

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    R = 1'b0; E = 1'b0; KEY = 4'b0000; data = 4'd0;
    sb_q.push_back(pack(4'd0, 1'b0, 1'b0, 1'b0, 1'b0));
    tick(3);
    exp_v = sb_q.pop_front(); got_v = observed(); checks++;
    if (got_v !== exp_v) begin
      errors++; $display("FAIL reset: got %b want %b", got_v, exp_v);
    end
    R = 1'b1;
    tick(1);
  endtask

  task automatic test_match_round();
    data = 4'd2; E = 1'b1;
    sb_q.push_back(pack(4'd0, 1'b0, 1'b0, 1'b0, 1'b1));
    tick(1);
    exp_v = sb_q.pop_front(); got_v = observed(); checks++;
    if (got_v !== exp_v) begin
      errors++; $display("FAIL enter_wait: got %b want %b", got_v, exp_v);
    end
    for (int i = 0; i < 3; i++) begin
      sb_q.push_back(pack(4'(i), 1'b0, 1'b0, 1'b0, 1'b1));
      if (i < 2) sb_q.push_back(pack(4'(i + 1), 1'b0, 1'b0, 1'b0, 1'b1));
      else       sb_q.push_back(pack(4'd2, 1'b1, 1'b0, 1'b0, 1'b0));
      KEY = rom[i];
      tick(1);
      exp_v = sb_q.pop_front(); got_v = observed(); checks++;
      if (got_v !== exp_v) begin
        errors++; $display("FAIL compare_cycle[%0d]: got %b want %b", i, got_v, exp_v);
      end
      tick(1);
      exp_v = sb_q.pop_front(); got_v = observed(); checks++;
      if (got_v !== exp_v) begin
        errors++; $display("FAIL press[%0d]: got %b want %b", i, got_v, exp_v);
      end
      KEY = 4'b0000;
      tick(1);
    end
    sb_q.push_back(pack(4'd2, 1'b1, 1'b0, 1'b0, 1'b0));
    tick(3);
    exp_v = sb_q.pop_front(); got_v = observed(); checks++;
    if (got_v !== exp_v) begin
      errors++; $display("FAIL tc_held: got %b want %b", got_v, exp_v);
    end
    E = 1'b0;
    sb_q.push_back(pack(4'd0, 1'b0, 1'b0, 1'b0, 1'b0));
    tick(1);
    exp_v = sb_q.pop_front(); got_v = observed(); checks++;
    if (got_v !== exp_v) begin
      errors++; $display("FAIL tc_clear: got %b want %b", got_v, exp_v);
    end
  endtask

  task automatic test_mismatch();
    data = 4'd2; E = 1'b1;
    tick(1);
    sb_q.push_back(pack(4'd1, 1'b0, 1'b0, 1'b0, 1'b1));
    sb_q.push_back(pack(4'd1, 1'b0, 1'b1, 1'b0, 1'b0));
    sb_q.push_back(pack(4'd0, 1'b0, 1'b0, 1'b0, 1'b0));
    KEY = 4'b0001; tick(2);
    exp_v = sb_q.pop_front(); got_v = observed(); checks++;
    if (got_v !== exp_v) begin
      errors++; $display("FAIL mismatch_first: got %b want %b", got_v, exp_v);
    end
    KEY = 4'b0000; tick(1);
    KEY = 4'b1000; tick(2);
    exp_v = sb_q.pop_front(); got_v = observed(); checks++;
    if (got_v !== exp_v) begin
      errors++; $display("FAIL mismatch_err: got %b want %b", got_v, exp_v);
    end
    KEY = 4'b0000; E = 1'b0; tick(1);
    exp_v = sb_q.pop_front(); got_v = observed(); checks++;
    if (got_v !== exp_v) begin
      errors++; $display("FAIL mismatch_clear: got %b want %b", got_v, exp_v);
    end
  endtask

  task automatic test_multikey();
    data = 4'd2; E = 1'b1;
    tick(1);
    sb_q.push_back(pack(4'd0, 1'b0, 1'b1, 1'b0, 1'b0));
    sb_q.push_back(pack(4'd0, 1'b0, 1'b0, 1'b0, 1'b0));
    KEY = 4'b0011; tick(2);
    exp_v = sb_q.pop_front(); got_v = observed(); checks++;
    if (got_v !== exp_v) begin
      errors++; $display("FAIL multikey: got %b want %b", got_v, exp_v);
    end
    KEY = 4'b0000; E = 1'b0; tick(1);
    exp_v = sb_q.pop_front(); got_v = observed(); checks++;
    if (got_v !== exp_v) begin
      errors++; $display("FAIL multikey_clear: got %b want %b", got_v, exp_v);
    end
  endtask

  task automatic test_hold();
    data = 4'd2; E = 1'b1;
    tick(1);
    sb_q.push_back(pack(4'd1, 1'b0, 1'b0, 1'b0, 1'b1));
    sb_q.push_back(pack(4'd2, 1'b0, 1'b0, 1'b0, 1'b1));
    KEY = 4'b0001; tick(20);
    exp_v = sb_q.pop_front(); got_v = observed(); checks++;
    if (got_v !== exp_v) begin
      errors++; $display("FAIL hold_one_event: got %b want %b", got_v, exp_v);
    end
    KEY = 4'b0000; tick(1);
    KEY = 4'b0100; tick(2);
    exp_v = sb_q.pop_front(); got_v = observed(); checks++;
    if (got_v !== exp_v) begin
      errors++; $display("FAIL hold_next_press: got %b want %b", got_v, exp_v);
    end
    KEY = 4'b0000; E = 1'b0; tick(1);
  endtask

  task automatic test_reset_midturn();
    data = 4'd2; E = 1'b1;
    tick(1);
    KEY = 4'b0001; tick(2); KEY = 4'b0000; tick(1);
    sb_q.push_back(pack(4'd0, 1'b0, 1'b0, 1'b0, 1'b0));
    #2 R = 1'b0;
    #1;
    exp_v = sb_q.pop_front(); got_v = observed(); checks++;
    if (got_v !== exp_v) begin
      errors++; $display("FAIL async_reset: got %b want %b", got_v, exp_v);
    end
    tick(1);
    R = 1'b1;
    sb_q.push_back(pack(4'd0, 1'b0, 1'b0, 1'b0, 1'b1));
    tick(1);
    exp_v = sb_q.pop_front(); got_v = observed(); checks++;
    if (got_v !== exp_v) begin
      errors++; $display("FAIL restart_wait: got %b want %b", got_v, exp_v);
    end
    for (int i = 0; i < 3; i++) begin
      if (i < 2) sb_q.push_back(pack(4'(i + 1), 1'b0, 1'b0, 1'b0, 1'b1));
      else       sb_q.push_back(pack(4'd2, 1'b1, 1'b0, 1'b0, 1'b0));
      KEY = rom[i]; tick(2);
      exp_v = sb_q.pop_front(); got_v = observed(); checks++;
      if (got_v !== exp_v) begin
        errors++; $display("FAIL restart_press[%0d]: got %b want %b", i, got_v, exp_v);
      end
      KEY = 4'b0000; tick(1);
    end
    E = 1'b0; tick(1);
  endtask

  task automatic test_limits();
    // Limit 0: first matching press completes the round.
    data = 4'd0; E = 1'b1;
    tick(1);
    sb_q.push_back(pack(4'd0, 1'b1, 1'b0, 1'b0, 1'b0));
    KEY = 4'b0001; tick(2);
    exp_v = sb_q.pop_front(); got_v = observed(); checks++;
    if (got_v !== exp_v) begin
      errors++; $display("FAIL limit_zero: got %b want %b", got_v, exp_v);
    end
    KEY = 4'b0000; E = 1'b0; tick(1);
    // Limit lowered below the current address mid-turn.
    data = 4'd2; E = 1'b1;
    tick(1);
    KEY = 4'b0001; tick(2); KEY = 4'b0000; tick(1);
    data = 4'd0;
    sb_q.push_back(pack(4'd1, 1'b0, 1'b1, 1'b0, 1'b0));
    KEY = 4'b0100; tick(2);
    exp_v = sb_q.pop_front(); got_v = observed(); checks++;
    if (got_v !== exp_v) begin
      errors++; $display("FAIL limit_lowered: got %b want %b", got_v, exp_v);
    end
    KEY = 4'b0000; E = 1'b0; tick(1);
    // Abort from WAIT_KEY: E falls with no flag set.
    data = 4'd2; E = 1'b1;
    tick(1);
    KEY = 4'b0001; tick(2); KEY = 4'b0000;
    E = 1'b0;
    sb_q.push_back(pack(4'd0, 1'b0, 1'b0, 1'b0, 1'b0));
    tick(1);
    exp_v = sb_q.pop_front(); got_v = observed(); checks++;
    if (got_v !== exp_v) begin
      errors++; $display("FAIL abort: got %b want %b", got_v, exp_v);
    end
  endtask

  task automatic test_timeout();
    data = 4'd2; E = 1'b1;
    tick(1);
`ifdef USER_TIMEOUT_EN
    sb_q.push_back(pack(4'd0, 1'b0, 1'b0, 1'b0, 1'b1));
    sb_q.push_back(pack(4'd0, 1'b0, 1'b1, 1'b1, 1'b0));
    tick(7);
    exp_v = sb_q.pop_front(); got_v = observed(); checks++;
    if (got_v !== exp_v) begin
      errors++; $display("FAIL tmo_before: got %b want %b", got_v, exp_v);
    end
    tick(1);
    exp_v = sb_q.pop_front(); got_v = observed(); checks++;
    if (got_v !== exp_v) begin
      errors++; $display("FAIL tmo_expire: got %b want %b", got_v, exp_v);
    end
    E = 1'b0; tick(1);
    E = 1'b1; tick(1);
    tick(7);
    sb_q.push_back(pack(4'd1, 1'b0, 1'b0, 1'b0, 1'b1));
    KEY = 4'b0001; tick(2);
    exp_v = sb_q.pop_front(); got_v = observed(); checks++;
    if (got_v !== exp_v) begin
      errors++; $display("FAIL tmo_key_wins: got %b want %b", got_v, exp_v);
    end
    KEY = 4'b0000;
`else
    sb_q.push_back(pack(4'd0, 1'b0, 1'b0, 1'b0, 1'b1));
    tick(12);
    exp_v = sb_q.pop_front(); got_v = observed(); checks++;
    if (got_v !== exp_v) begin
      errors++; $display("FAIL no_timeout: got %b want %b", got_v, exp_v);
    end
`endif
    E = 1'b0; tick(1);
  endtask

  initial begin
    errors = 0;
    checks = 0;
    for (int i = 0; i < 16; i++) rom[i] = 4'b1000;
    rom[0] = 4'b0001;
    rom[1] = 4'b0100;
    rom[2] = 4'b0010;
    rom_q  = 4'b0000;
    test_reset();
    test_match_round();
    test_mismatch();
    test_multikey();
    test_hold();
    test_reset_midturn();
    test_limits();
    test_timeout();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/user_seq_checker.md
# user_seq_checker

Player-side counterpart of the FPGA sequence counter in the memory-game datapath. It walks the ROM address from 0 up to the current round limit, one step per player key press, and compares each press against the ROM symbol. It reports round success (`tc`), wrong key (`err`) or, optionally, inactivity timeout. It sits between the debounced key inputs, the sequence ROM's second read port and the game controller FSM.

## Interface
- `P_DATA`, 4: width of `data` and `SEQUSR`.
- `P_KEY`, 4: number of player keys; also the width of one-hot `KEY` and `rom_q`.
- `P_TIMEOUT`, 1000: inactivity limit in clock cycles. Used only with `USER_TIMEOUT_EN`; must be ≥ 2.
- `clk`  in  1  single clock; all state updates on rising edge.
- `R`  in  1  asynchronous, active-low reset.
- `E`  in  1  enable level from the controller. High means a player turn is active.
- `KEY`  in  P_KEY  debounced, active-high keys.
- `data`  in  P_DATA  round limit: the last valid ROM address.
- `rom_q`  in  P_KEY  one-hot expected symbol. Registered ROM output, valid 1 cycle after `SEQUSR`.
- `SEQUSR`  out  P_DATA  ROM address of the symbol under test.
- `tc`  out  1  whole round matched; held until `E` falls.
- `err`  out  1  mismatch, multi-key press, or timeout; held until `E` falls.
- `tmo`  out  1  error cause was timeout. Always 0 without `USER_TIMEOUT_EN`.
- `busy`  out  1  high in WAIT_KEY and COMPARE.

## Operation
- Reset (`R` = 0): state IDLE. `SEQUSR`, `tc`, `err`, `tmo`, `busy`, key history, captured key and timeout counter are all 0.
- States: IDLE, WAIT_KEY, COMPARE, DONE_OK, DONE_ERR.
- IDLE: while `E` = 1, go to WAIT_KEY with `SEQUSR` = 0.
- Key event: a bit of `KEY` is 1 now and was 0 in the previous cycle. Holding a key produces one event only.
- WAIT_KEY:
  - Exactly one rising bit and no other `KEY` bit high: capture the one-hot value and go to COMPARE.
  - Any other non-zero rising pattern: go to DONE_ERR.
- COMPARE, one cycle:
  - Captured key ≠ `rom_q`: go to DONE_ERR.
  - Match and `SEQUSR` == `data`: go to DONE_OK.
  - Match and `SEQUSR` < `data`: `SEQUSR` + 1, back to WAIT_KEY.
  - `SEQUSR` > `data` (limit lowered mid-turn): go to DONE_ERR.
- Address arithmetic: unsigned, never wraps. `SEQUSR` maximum is `data` ≤ 2^P_DATA − 1.
- DONE_OK raises `tc`; DONE_ERR raises `err`. Both states hold until `E` = 0, then go to IDLE, where `tc`, `err` and `tmo` clear.
- `E` falling in WAIT_KEY or COMPARE aborts to IDLE: `SEQUSR` = 0, no flag set.
- Async reset asserted in any state gives the reset values immediately. On release, operation resumes from IDLE.

## Timing
- Key rising in cycle n: COMPARE in cycle n+1; the new `SEQUSR` is visible in cycle n+2.
- `rom_q` for the new address is valid at n+3. The earliest next key event is at n+2, so its COMPARE falls at n+3. The 1-cycle ROM latency is therefore always met, with no stall.
- `tc`/`err` rise in the cycle after COMPARE and are registered outputs.
- IDLE → WAIT_KEY takes 1 cycle after `E` is sampled high.

## Configuration
- `USER_TIMEOUT_EN` defined:
  - A counter runs in WAIT_KEY and clears on entry to WAIT_KEY.
  - When it reaches `P_TIMEOUT` − 1 with no key event, go to DONE_ERR with `err` = `tmo` = 1.
  - A key event in the same cycle as expiry wins: no timeout.
- Not defined: no counter logic; `tmo` is tied to 0.

## Structure
- Package `user_seq_pkg`: state enum, `P_DATA`/`P_KEY` default constants, one-hot check function.
- Sub-module `key_edge_detect`: registers `KEY` and outputs per-bit rising pulses plus a `single` flag. Instantiated once.

## Test plan
- `data` = 2, ROM {0001, 0100, 0010}, presses 0001, 0100, 0010 → `SEQUSR` goes 0, 1, 2; `tc` = 1 two cycles after the third press; `err` = 0.
- `data` = 2, second press 1000 while `rom_q` = 0100 → `err` = 1, `tc` = 0, `SEQUSR` stays 1. After `E` drops → IDLE with all flags 0.
- Press 0011 in one cycle → `err` = 1. Key 0001 held 20 cycles → exactly one compare.
- `R` pulsed low mid-turn at `SEQUSR` = 1 → all outputs 0 at once. Restart with `E` = 1 → fresh turn from address 0.
- With `USER_TIMEOUT_EN` and `P_TIMEOUT` = 8: no key for 8 cycles → `err` = `tmo` = 1. Key on the expiry cycle → no error.
